pc_sequencer: RTL and testbench

- Parametrised fetch-address generator; next generation of the single-cycle PC update logic.
- Generalised address width and branch-resolution lag.
- Adds fetch stall, a PC history pipe for correct branch base, and wrong-path branch suppression (shadow counter).
- Sits at the front of the pipelined CPU; drives the instruction-memory address and accepts branch resolution from the execute stage.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_sequencer_history.sv | 29 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants and the branch-offset helper for the fetch-address sequencer.
package pc_seq_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMM26_MSB  = 25;
  localparam int unsigned IMM19_MSB  = 23;
  localparam int unsigned IMM19_LSB  = 5;
  localparam int unsigned BL_BIT     = 31;
  localparam int unsigned PC_STEP    = 4;

  localparam int unsigned IMM26_W    = IMM26_MSB + 1;
  localparam int unsigned IMM19_W    = IMM19_MSB - IMM19_LSB + 1;
  // Widest address the offset helper can produce.
  localparam int unsigned MAX_ADDR_W = 128;
  // Enough to hold LAG up to 4.
  localparam int unsigned SHADOW_W   = 3;

  // Sign-extend the low imm_w bits of imm, scale by 4, and keep addr_w bits.
  function automatic logic [MAX_ADDR_W-1:0] sext_shift(input logic [IMM26_W-1:0] imm,
                                                       input int unsigned imm_w,
                                                       input int unsigned addr_w);
    logic [MAX_ADDR_W-1:0] v;
    v = {{(MAX_ADDR_W - IMM26_W){1'b0}}, imm};
    // Park the immediate's sign bit at the MSB, then shift back arithmetically.
    v = v << (MAX_ADDR_W - imm_w);
    v = $signed(v) >>> (MAX_ADDR_W - imm_w - 2);
    v = v & ({MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - addr_w));
    return v;
  endfunction

endpackage

// File: rtl/pc_sequencer_history.sv
// LAG-deep shift register of past fetch addresses; tail_o is the PC fetched LAG
// advancing cycles ago, i.e. the address of the branch now resolving.
module pc_sequencer_history #(
  parameter int unsigned          ADDR_W   = 64,
  parameter int unsigned          LAG      = 1,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] tail_o
);

  logic [ADDR_W-1:0] hist_q [LAG];

  // Shift in the current PC on every advancing cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < LAG; k++) hist_q[k] <= RESET_PC;
    end else if (en_i) begin
      hist_q[0] <= pc_i;
      for (int k = 1; k < LAG; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  assign tail_o = hist_q[LAG-1];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: sequential PC, branch redirect with a wrong-path
// shadow, fetch stall. Optional BL link capture enabled by macro PC_SEQ_LINK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       LAG      = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               br_uncond,
  input  logic [INSTR_W-1:0] br_instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               redirect,
  output logic               link_valid,
  output logic [ADDR_W-1:0]  link_addr
);

  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                redirect_q, redirect_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0]   br_pc, offset, target;
  logic [IMM26_W-1:0]  imm;
  logic                accept;
  logic                unused_instr;

  pc_sequencer_history #(
    .ADDR_W   (ADDR_W),
    .LAG      (LAG),
    .RESET_PC (RESET_PC)
  ) u_history (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (!stall),
    .pc_i    (pc_q),
    .tail_o  (br_pc)
  );

  assign unused_instr = ^br_instr[INSTR_W-1:IMM26_W];

  assign imm    = br_uncond ? br_instr[IMM26_MSB:0]
                            : {{(IMM26_W - IMM19_W){1'b0}}, br_instr[IMM19_MSB:IMM19_LSB]};
  assign offset = ADDR_W'(sext_shift(imm, br_uncond ? IMM26_W : IMM19_W, ADDR_W));
  assign target = br_pc + offset;
  // Branches inside the shadow are wrong-path fetches and are dropped.
  assign accept = br_taken && !stall && (shadow_q == '0);

  // Next PC, redirect flag and shadow countdown; stall holds everything.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = redirect_q;
    shadow_d   = shadow_q;
    if (!stall) begin
      pc_d       = pc_q + ADDR_W'(PC_STEP);
      redirect_d = 1'b0;
      if (shadow_q != '0) shadow_d = shadow_q - 1'b1;
      if (accept) begin
        pc_d       = target;
        redirect_d = 1'b1;
        shadow_d   = SHADOW_W'(LAG);
      end
    end
  end

  // Sequencer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      shadow_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      shadow_q   <= shadow_d;
    end
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;

`ifdef PC_SEQ_LINK_EN
  logic              link_valid_q, link_valid_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  // Capture the return address of an accepted BL; hold it until the next one.
  always_comb begin
    link_valid_d = accept && br_uncond && br_instr[BL_BIT];
    link_addr_d  = link_valid_d ? br_pc + ADDR_W'(PC_STEP) : link_addr_q;
  end

  // Link registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_valid = link_valid_q;
  assign link_addr  = link_addr_q;
`else
  assign link_valid = 1'b0;
  assign link_addr  = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: three instances (LAG=1/64-bit, LAG=2,
// 32-bit) share one stimulus bus; each phase starts with a reset.
module tb_pc_sequencer;

`ifdef PC_SEQ_LINK_EN
  localparam bit LinkEn = 1'b1;
`else
  localparam bit LinkEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, br_taken, br_uncond;
  logic [31:0] br_instr;

  logic [63:0] a_pc, a_link_addr, b_pc, b_link_addr;
  logic [31:0] c_pc, c_link_addr;
  logic        a_red, a_lv, b_red, b_lv, c_red, c_lv;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.ADDR_W(64), .LAG(1), .RESET_PC(64'h0)) u_dut_a (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_uncond(br_uncond),
    .br_instr(br_instr), .pc(a_pc), .redirect(a_red), .link_valid(a_lv),
    .link_addr(a_link_addr)
  );

  pc_sequencer #(.ADDR_W(64), .LAG(2), .RESET_PC(64'h38)) u_dut_b (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_uncond(br_uncond),
    .br_instr(br_instr), .pc(b_pc), .redirect(b_red), .link_valid(b_lv),
    .link_addr(b_link_addr)
  );

  pc_sequencer #(.ADDR_W(32), .LAG(1), .RESET_PC(32'hFFFF_FFF4)) u_dut_c (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_uncond(br_uncond),
    .br_instr(br_instr), .pc(c_pc), .redirect(c_red), .link_valid(c_lv),
    .link_addr(c_link_addr)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        tkn;
    logic        unc;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        red;
  } vec_t;

  localparam int NVec = 20;
  vec_t vecs [NVec];

  localparam logic [31:0] CondP3  = 32'h5400_0060;  // imm19 = +3
  localparam logic [31:0] CondM1  = 32'h54FF_FFE0;  // imm19 = -1
  localparam logic [31:0] UncP4   = 32'h1400_0004;  // B, imm26 = +4
  localparam logic [31:0] UncM2   = 32'h17FF_FFFE;  // B, imm26 = -2
  localparam logic [31:0] BlP8    = 32'h9400_0008;  // BL, imm26 = +8

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic tkn, input logic unc,
                       input logic [31:0] instr);
    reset     = rst;
    stall     = stl;
    br_taken  = tkn;
    br_uncond = unc;
    br_instr  = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst   stl   tkn   unc   instr   pc       red
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  64'd0,   1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd4,   1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd8,   1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd12,  1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd16,  1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, CondP3, 64'd24,  1'b1};  // 12 + 12
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, CondP3, 64'd28,  1'b0};  // shadow: ignored
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd32,  1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, UncP4,  64'd32,  1'b0};  // stall wins
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, UncP4,  64'd32,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, UncP4,  64'd32,  1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, UncP4,  64'd44,  1'b1};  // 28 + 16
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  64'd44,  1'b1};  // redirect held
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, CondP3, 64'd48,  1'b0};  // shadow: ignored
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, CondM1, 64'd40,  1'b1};  // 44 - 4
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  64'd0,   1'b0};  // reset mid-shadow
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, CondP3, 64'd12,  1'b1};  // shadow cleared
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd16,  1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  64'd0,   1'b0};  // reset beats stall
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  64'd4,   1'b0};

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].tkn, vecs[i].unc, vecs[i].instr);
      tick();
      check($sformatf("a_pc[%0d]", i), a_pc, vecs[i].pc);
      check($sformatf("a_redirect[%0d]", i), 64'(a_red), 64'(vecs[i].red));
      check($sformatf("a_link_valid[%0d]", i), 64'(a_lv), 64'd0);
      check($sformatf("a_link_addr[%0d]", i), a_link_addr, 64'd0);
    end

    // BL at 0x100 resolves while fetching 0x104: target 0x120, link 0x104.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 65; i++) tick();
    check("a_pc_pre_bl", a_pc, 64'h104);
    drive(1'b0, 1'b0, 1'b1, 1'b1, BlP8);
    tick();
    check("a_pc_bl", a_pc, 64'h120);
    check("a_redirect_bl", 64'(a_red), 64'd1);
    check("a_link_valid_bl", 64'(a_lv), 64'(LinkEn));
    check("a_link_addr_bl", a_link_addr, LinkEn ? 64'h104 : 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("a_pc_after_bl", a_pc, 64'h124);
    check("a_link_valid_after_bl", 64'(a_lv), 64'd0);
    check("a_link_addr_after_bl", a_link_addr, LinkEn ? 64'h104 : 64'h0);

    // LAG=2: branch fetched at 0x40 resolves while fetching 0x48.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("b_pc_reset", b_pc, 64'h38);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("b_pc_seq[%0d]", i), b_pc, 64'h38 + 64'(4 * i));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, UncM2);
    tick();
    check("b_pc_br", b_pc, 64'h38);
    check("b_redirect_br", 64'(b_red), 64'd1);
    tick();
    check("b_pc_shadow1", b_pc, 64'h3C);
    check("b_redirect_shadow1", 64'(b_red), 64'd0);
    tick();
    check("b_pc_shadow2", b_pc, 64'h40);
    tick();
    check("b_pc_br2", b_pc, 64'h30);  // base is the 0x38 fetch two cycles back
    check("b_redirect_br2", 64'(b_red), 64'd1);

    // 32-bit wrap, then reset in the middle of a shadow.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("c_pc_reset", 64'(c_pc), 64'hFFFF_FFF4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("c_pc_top", 64'(c_pc), 64'hFFFF_FFFC);
    tick();
    check("c_pc_wrap", 64'(c_pc), 64'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, CondM1);
    tick();
    check("c_pc_br_wrap", 64'(c_pc), 64'hFFFF_FFF8);
    check("c_redirect_br", 64'(c_red), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("c_pc_mid_shadow_reset", 64'(c_pc), 64'hFFFF_FFF4);
    check("c_redirect_reset", 64'(c_red), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, CondM1);
    tick();
    check("c_pc_br_after_reset", 64'(c_pc), 64'hFFFF_FFF0);
    check("c_redirect_after_reset", 64'(c_red), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
